// File: rtl/key_beep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_beep_ctrl
//  Description : Key-driven buzzer controller. Each falling edge of the
//                debounced key steps IDLE -> TONE -> PATTERN -> IDLE.
//                TONE drives a continuous square wave; PATTERN gates the same
//                square wave with a repeating on/off envelope.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_beep_ctrl #(
    parameter logic [15:0] TONE_DIV = 16'd12500,      // tone half-period in clocks
    parameter logic [25:0] BEEP_ON  = 26'd12_500_000, // envelope on-time in clocks
    parameter logic [25:0] BEEP_OFF = 26'd12_500_000  // envelope off-time in clocks
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_flt,
    output logic       beep,
    output logic [1:0] beep_state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Terminal counts are precomputed; the pattern period is formed in 27 bits
    // so that BEEP_ON + BEEP_OFF can never overflow.
    localparam logic [15:0] C_TONE_LAST = TONE_DIV - 16'd1;
    localparam logic [26:0] C_PAT_ON    = {1'b0, BEEP_ON};
    localparam logic [26:0] C_PAT_LAST  = {1'b0, BEEP_ON} + {1'b0, BEEP_OFF} - 27'd1;

    // ------------------------------------------------------------------------
    // State encoding (2'd3 is never produced and recovers to IDLE)
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TONE    = 2'd1,
        ST_PATTERN = 2'd2
    } state_t;

    state_t      state;
    logic        key_d;
    logic [15:0] tone_cnt;
    logic        tone_sq;
    logic [26:0] pat_cnt;

    logic        press;
    logic        tone_wrap;
    logic        pat_wrap;
    logic        gate;
    state_t      state_next;

    // ------------------------------------------------------------------------
    // Combinational decode of press, wraps, envelope and next state
    // ------------------------------------------------------------------------
    assign press     = key_d & ~key_flt;          // only the 1->0 edge counts
    assign tone_wrap = (tone_cnt == C_TONE_LAST);
    assign pat_wrap  = (pat_cnt == C_PAT_LAST);
    assign gate      = (pat_cnt < C_PAT_ON);

    // Next state taken on a press; any unexpected encoding falls back to IDLE.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:    state_next = ST_TONE;
            ST_TONE:    state_next = ST_PATTERN;
            ST_PATTERN: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, key history and tone/pattern counters
    // ------------------------------------------------------------------------
    // A press always wins over a counter wrap: the state advances and all
    // counters restart from zero on that same edge, so the new mode begins
    // with a fresh half-period and a fresh envelope.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            key_d    <= 1'b1;
            tone_cnt <= 16'd0;
            tone_sq  <= 1'b0;
            pat_cnt  <= 27'd0;
        end else begin
            key_d <= key_flt;
            if (press) begin
                state    <= state_next;
                tone_cnt <= 16'd0;
                tone_sq  <= 1'b0;
                pat_cnt  <= 27'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tone_cnt <= 16'd0;
                        tone_sq  <= 1'b0;
                        pat_cnt  <= 27'd0;
                    end
                    ST_TONE: begin
                        if (tone_wrap) begin
                            tone_cnt <= 16'd0;
                            tone_sq  <= ~tone_sq;
                        end else begin
                            tone_cnt <= tone_cnt + 16'd1;
                        end
                        pat_cnt <= 27'd0;
                    end
                    ST_PATTERN: begin
                        if (tone_wrap) begin
                            tone_cnt <= 16'd0;
                            tone_sq  <= ~tone_sq;
                        end else begin
                            tone_cnt <= tone_cnt + 16'd1;
                        end
                        if (pat_wrap) begin
                            pat_cnt <= 27'd0;
                        end else begin
                            pat_cnt <= pat_cnt + 27'd1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        tone_cnt <= 16'd0;
                        tone_sq  <= 1'b0;
                        pat_cnt  <= 27'd0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Buzzer drive decoded from registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        beep = 1'b0;
        case (state)
            ST_TONE:    beep = tone_sq;
            ST_PATTERN: beep = tone_sq & gate;
            default:    beep = 1'b0;
        endcase
    end

    assign beep_state = state;

endmodule
`default_nettype wire

// File: tb/tb_key_beep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_beep_ctrl
//  Description : Scoreboard bench for key_beep_ctrl. A cycle-based reference
//                model tracks mode and time-in-mode, pushes the expected
//                outputs at each rising edge; they are popped and compared on
//                the following falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_beep_ctrl;

    localparam int TD  = 3;
    localparam int BON = 10;
    localparam int BOF = 10;

    logic       clk;
    logic       rst;
    logic       key;
    logic       beep;
    logic [1:0] beep_state;

    key_beep_ctrl #(
        .TONE_DIV (16'd3),
        .BEEP_ON  (26'd10),
        .BEEP_OFF (26'd10)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .key_flt    (key),
        .beep       (beep),
        .beep_state (beep_state)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        bp;
        logic [1:0]  st;
        logic [15:0] tc;
        logic [26:0] pc;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Single comparison point: counts and reports
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode plus cycles spent in the mode
    int   m_st = 0;
    int   m_t  = 0;
    logic m_kd = 1'b1;

    // Advance the model at each rising edge and queue the expected outputs
    always @(posedge clk) begin
        exp_t e;
        int   sq;
        if (rst) begin
            m_st = 0;
            m_kd = 1'b1;
            m_t  = 0;
        end else begin
            if (m_kd && !key) begin
                m_st = (m_st == 2) ? 0 : m_st + 1;
                m_t  = 0;
            end else if (m_st == 0) begin
                m_t = 0;
            end else begin
                m_t = m_t + 1;
            end
            m_kd = key;
        end
        sq   = (m_t / TD) % 2;
        e.st = m_st[1:0];
        e.tc = (m_st == 0) ? 16'd0 : 16'(m_t % TD);
        e.pc = (m_st == 2) ? 27'(m_t % (BON + BOF)) : 27'd0;
        if (m_st == 1)      e.bp = sq[0];
        else if (m_st == 2) e.bp = sq[0] && ((m_t % (BON + BOF)) < BON);
        else                e.bp = 1'b0;
        q.push_back(e);
    end

    // Compare DUT outputs half a cycle after each edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_eq("beep_state", 32'(beep_state), 32'(e.st));
            check_eq("beep", 32'(beep), 32'(e.bp));
            check_eq("tone_cnt", 32'(dut.tone_cnt), 32'(e.tc));
            check_eq("pat_cnt", 32'(dut.pat_cnt), 32'(e.pc));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int low_cycles, input int high_cycles);
        key = 1'b0;
        cycles(low_cycles);
        key = 1'b1;
        cycles(high_cycles);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        key = 1'b1;
        cycles(10);
        rst = 1'b0;
        cycles(50);                 // idle, silent

        press_key(20, 30);          // -> TONE
        press_key(20, 60);          // -> PATTERN, three envelope periods
        press_key(3, 10);           // -> IDLE
        press_key(3, 10);           // -> TONE, tone restarts from zero

        // Press landing on a tone_cnt wrap cycle
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (dut.tone_cnt == 16'd2) found = 1'b1;
        end
        check_eq("wrap_cycle_found", 32'(found), 32'd1);
        press_key(2, 15);           // -> PATTERN

        // Wait for audible output in PATTERN, then pulse reset with key low
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (beep === 1'b1) found = 1'b1;
        end
        check_eq("pattern_beep_seen", 32'(found), 32'd1);
        key = 1'b0;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(5);                  // exactly one press after release -> TONE
        key = 1'b1;
        cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
